// File: rtl/siso_sched_pkg.sv
// siso_sched_pkg: shared types and counter-width helper for the siso_sched scheduler.
package siso_sched_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_SHIFT = S_SHIFT,
        ST_GAP   = S_GAP
    } state_t;

    typedef logic owner_t;

    // Width of a counter covering 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/siso_sched_if.sv
// siso_sched_if: requester handshakes and serial-line outputs of the scheduler.
interface siso_sched_if
    import siso_sched_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             se_out;
    logic             frame_active;
    owner_t           frame_owner;
    logic             frame_done;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, se_out, frame_active, frame_owner, frame_done
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, se_out, frame_active, frame_owner, frame_done
    );

endinterface

// File: rtl/siso_sched_piso.sv
// siso_sched_piso: parallel-load, LSB-first shift register with a saturating bit counter.
module siso_sched_piso
    import siso_sched_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             bit0_o,
    output logic             last_o
);
    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign bit0_o = sreg_q[0];
    assign last_o = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        sreg_d = load_i ? din_i : shift_i ? sreg_q >> 1 : sreg_q;
        cnt_d  = load_i ? '0 : (shift_i && !last_o) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/siso_sched.sv
// siso_sched: round-robin scheduler for two requesters sharing one LSB-first serial
// line, with GAP forced-low cycles after every frame.
module siso_sched
    import siso_sched_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input logic         clk,
    input logic         rst_n,
    siso_sched_if.slave bus
);
    localparam int GW = cnt_w(GAP + 1);

    state_t        state_q, state_d;
    owner_t        last_grant_q, last_grant_d;
    owner_t        owner_q, owner_d;
    owner_t        frame_owner_q, frame_owner_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          se_out_q, se_out_d;
    logic          frame_active_q, frame_active_d;
    logic          frame_done_q, frame_done_d;
    logic          idle, shifting, grant0, grant1, accept, gap_done, bit0, last;

    assign idle     = state_q == ST_IDLE;
    assign shifting = state_q == ST_SHIFT;
    assign gap_done = gcnt_q == GW'(GAP - 1);

    // On a tie the requester that was not granted last wins.
    assign grant0 = bus.req0_valid && !(bus.req1_valid && last_grant_q == 1'b0);
    assign grant1 = bus.req1_valid && !(bus.req0_valid && last_grant_q == 1'b1);

    assign bus.req0_ready = rst_n && idle && grant0;
    assign bus.req1_ready = rst_n && idle && grant1;
    assign accept         = bus.req0_ready || bus.req1_ready;

    assign bus.se_out       = se_out_q;
    assign bus.frame_active = frame_active_q;
    assign bus.frame_owner  = frame_owner_q;
    assign bus.frame_done   = frame_done_q;

    siso_sched_piso #(.WIDTH(WIDTH)) u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .shift_i (shifting),
        .din_i   (bus.req1_ready ? bus.req1_data : bus.req0_data),
        .bit0_o  (bit0),
        .last_o  (last)
    );

    always_comb begin
        state_d        = idle     ? (accept ? ST_SHIFT : ST_IDLE)
                       : shifting ? (!last ? ST_SHIFT : (GAP == 0) ? ST_IDLE : ST_GAP)
                       : (gap_done ? ST_IDLE : ST_GAP);
        gcnt_d         = (state_q == ST_GAP && !gap_done) ? gcnt_q + 1'b1 : '0;
        last_grant_d   = accept ? bus.req1_ready : last_grant_q;
        owner_d        = accept ? bus.req1_ready : owner_q;
        se_out_d       = shifting && bit0;
        frame_active_d = shifting;
        frame_owner_d  = shifting ? owner_q : frame_owner_q;
        frame_done_d   = shifting && last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            gcnt_q         <= '0;
            se_out_q       <= 1'b0;
            frame_active_q <= 1'b0;
            frame_owner_q  <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            gcnt_q         <= gcnt_d;
            se_out_q       <= se_out_d;
            frame_active_q <= frame_active_d;
            frame_owner_q  <= frame_owner_d;
            frame_done_q   <= frame_done_d;
        end
    end

endmodule

// File: doc/siso_sched.md
# siso_sched

Two-requester scheduler for a shared serial shift line. Accepts parallel WIDTH-bit words from two independent requesters over valid/ready handshakes and arbitrates round-robin between them. Serializes each granted word LSB-first onto one serial output, with guaranteed idle gaps between frames. Sits in front of downstream serial-in consumers (SISO chains) as the single owner of the line.

## Interface

Parameters:

- WIDTH, 4, bits per frame (≥2)
- GAP, 1, extra forced-low cycles after each frame (≥0)

Ports:

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has a word
- req0_data  in  WIDTH  requester 0 word
- req0_ready  out  1  requester 0 word accepted this edge
- req1_valid  in  1  requester 1 has a word
- req1_data  in  WIDTH  requester 1 word
- req1_ready  out  1  requester 1 word accepted this edge
- se_out  out  1  serial line, registered
- frame_active  out  1  se_out carries a frame bit, registered
- frame_owner  out  1  requester index of the current frame, registered
- frame_done  out  1  one-cycle pulse coinciding with the last bit on se_out

## Operation

- FSM states:
  - IDLE → SHIFT on an accepted word.
  - SHIFT → GAP after bit WIDTH-1 is launched, or → IDLE directly if GAP=0.
  - GAP → IDLE after GAP cycles.
- Handshake:
  - Transfer occurs on a rising edge with valid && ready.
  - readyN is combinational: state==IDLE && grantN.
  - Requesters hold valid and data stable until ready; valid does not depend on ready.
- Arbitration:
  - Only one request valid → it wins.
  - Both valid → winner is the requester not granted last.
  - last_grant updates only on an accepted transfer.
  - At most one ready high per cycle.
- Accept edge:
  - shift register ← data; bit counter ← 0; owner latched.
- SHIFT, each edge:
  - se_out ← sreg[0]; sreg ← sreg >> 1; frame_active ← 1; frame_owner ← owner; counter++.
  - frame_done ← 1 only on the edge launching bit WIDTH-1.
- IDLE and GAP: se_out ← 0, frame_active ← 0, frame_done ← 0.
- Counter widths: clog2(WIDTH) for bits, clog2(GAP+1) for gap; no wrap beyond terminal values.

## Timing

- Reset values (async assert, while rst=0):
  - state IDLE; se_out, frame_active, frame_owner, frame_done all 0; sreg 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - Ready outputs stay low during reset.
- Latency: word accepted at edge T puts bit k on se_out during the cycle after edge T+1+k, for k = 0..WIDTH-1. frame_done is high in the cycle after edge T+WIDTH.
- Saturated throughput: one frame per WIDTH+GAP+1 cycles. se_out is low for at least GAP+1 cycles between frames.
- Reset mid-frame: the frame is abandoned immediately with no further bits. After release, the FSM resumes from IDLE.
- A request arriving during SHIFT or GAP waits; it is not dropped.

## Structure

- Shared package siso_sched_pkg holds:
  - state_t enum: IDLE, SHIFT, GAP.
  - owner_t (1-bit requester index).
  - The clog2-based width helper for the counters.
- Sub-module siso_sched_piso: load/shift register plus bit counter. Ports: load, shift, din, bit0, last.
- The top level holds the FSM, arbiter, gap counter and output registers.

## Test plan

- Reset, then req0 only with data 4'b1011 → req0_ready pulses once; se_out is 1,1,0,1 on consecutive cycles starting two cycles after accept; frame_done with the final 1; frame_owner=0.
- Both valid and held, data0=4'hA, data1=4'h5 → grants alternate 0,1,0,1; frames spaced WIDTH+GAP+1=6 cycles apart; se_out is low exactly 2 cycles between frames.
- GAP=0 build, req1 continuous → frames every 5 cycles; exactly one low cycle between frames; req0_ready never asserts.
- rst pulsed low after bit 1 of a frame → all outputs 0 immediately; next tie after release goes to req0.
- req1 asserts during req0's SHIFT → req1_ready stays low until IDLE; req1 accepted at the first IDLE edge; req1's frame is transmitted intact.
- Random valid toggling with the protocol respected over 1000 cycles → never both readys high; every accepted word appears exactly once, LSB-first, with the correct owner.
